// File: rtl/common_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : common_types_pkg
//  Purpose  : Shared types for the fetch stage: 32-bit word type, fetch
//             sequencer state encoding, the NOP instruction word, the
//             fetch-to-decode entry record and a word-alignment helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package common_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // RV32I canonical NOP: addi x0, x0, 0
  localparam word_t NOP_INST = 32'h0000_0013;

  // One instruction as presented to decode
  typedef struct packed {
    word_t pc;
    word_t inst;
    logic  pred;
    word_t target;
  } f2d_entry_t;

  // Instructions are 4-byte aligned; the two low address bits are dropped
  function automatic word_t align_word(input word_t a);
    return a & ~word_t'(32'h3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl
//  Purpose  : Fetch-stage sequencer. Owns the PC, runs the instruction-memory
//             request handshake, buffers an instruction when decode stalls,
//             and drains abandoned requests after an execute redirect.
//  Ports    : CLK, nRST                  clock / async active-low reset
//             iren, iaddr                instruction read request / address
//             ihready, irdata            memory done / instruction word
//             stall                      decode cannot accept
//             redirect, redirect_pc      execute-stage PC redirect
//             pred_taken, pred_target    BTB prediction for current pc
//             f2d_en, f2d_flush          fetch-to-decode latch load / clear
//             f2d_pc, f2d_inst,
//             f2d_pred, f2d_target       entry presented to the latch
//  Revision : 1.0  initial release
// ============================================================================
module fetch_ctrl
  import common_types_pkg::*;
#(
  parameter word_t       RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic  CLK,
  input  logic  nRST,
  output logic  iren,
  output word_t iaddr,
  input  logic  ihready,
  input  word_t irdata,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  pred_taken,
  input  word_t pred_target,
  output logic  f2d_en,
  output logic  f2d_flush,
  output word_t f2d_pc,
  output word_t f2d_inst,
  output logic  f2d_pred,
  output word_t f2d_target
);

  fetch_state_t state, state_nx;
  word_t        pc, pc_nx;
  word_t        drain_addr, drain_addr_nx;
  f2d_entry_t   hold, hold_nx;
  word_t        seq_pc;

  // Next sequential PC, steered by the BTB (32-bit wraparound is intended)
  assign seq_pc = pred_taken ? align_word(pred_target) : pc + word_t'(PC_STEP);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= RESET;
      pc          <= RESET_PC;
      drain_addr  <= '0;
      hold.pc     <= '0;
      hold.inst   <= NOP_INST;
      hold.pred   <= 1'b0;
      hold.target <= '0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      drain_addr <= drain_addr_nx;
      hold       <= hold_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    drain_addr_nx = drain_addr;
    hold_nx       = hold;
    iren          = 1'b0;
    iaddr         = pc;
    f2d_en        = 1'b0;
    f2d_flush     = 1'b0;
    f2d_pc        = pc;
    f2d_inst      = NOP_INST;
    f2d_pred      = 1'b0;
    f2d_target    = '0;

    case (state)
      RESET: begin
        f2d_flush = 1'b1;
        state_nx  = FETCH;
        if (redirect) pc_nx = align_word(redirect_pc);
      end

      FETCH: begin
        // Request stays up even on redirect: the bus cannot be retracted
        iren       = 1'b1;
        f2d_pc     = pc;
        f2d_inst   = irdata;
        f2d_pred   = pred_taken;
        f2d_target = pred_target;
        if (redirect) begin
          f2d_flush = 1'b1;
          pc_nx     = align_word(redirect_pc);
          if (!ihready) begin
            // Remember the in-flight address so it stays stable until done
            state_nx      = DRAIN;
            drain_addr_nx = pc;
          end
        end else if (ihready) begin
          pc_nx = seq_pc;
          if (stall) begin
            hold_nx.pc     = pc;
            hold_nx.inst   = irdata;
            hold_nx.pred   = pred_taken;
            hold_nx.target = pred_target;
            state_nx       = HOLD;
          end else begin
            f2d_en = 1'b1;
          end
        end
      end

      HOLD: begin
        f2d_pc     = hold.pc;
        f2d_inst   = hold.inst;
        f2d_pred   = hold.pred;
        f2d_target = hold.target;
        if (redirect) begin
          f2d_flush = 1'b1;
          pc_nx     = align_word(redirect_pc);
          state_nx  = FETCH;
        end else if (!stall) begin
          f2d_en   = 1'b1;
          state_nx = FETCH;
        end
      end

      DRAIN: begin
        // Returned data belongs to an abandoned request and is dropped
        iren  = 1'b1;
        iaddr = drain_addr;
        if (redirect) begin
          f2d_flush = 1'b1;
          pc_nx     = align_word(redirect_pc);
        end
        if (ihready) state_nx = FETCH;
      end

      default: state_nx = RESET;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_ctrl
//  Purpose  : Self-checking bench for fetch_ctrl: directed scenarios followed
//             by randomized traffic, checked against a transaction-level model
//             of the bus request and an in-order program-flow scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iren;
  logic [31:0] iaddr;
  logic        ihready;
  logic [31:0] irdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        f2d_en;
  logic        f2d_flush;
  logic [31:0] f2d_pc;
  logic [31:0] f2d_inst;
  logic        f2d_pred;
  logic [31:0] f2d_target;

  // stimulus knobs
  logic [31:0] junk;
  logic        btb_on, dir_on;
  logic [31:0] dir_pc, dir_tgt;

  int total = 0;
  int bad   = 0;

  // reference model
  bit          m_fresh;     // first cycle out of reset, nothing requested yet
  bit          m_held;      // one instruction fetched, waiting for decode
  bit          m_ghost;     // abandoned request still outstanding on the bus
  logic [31:0] m_pc;        // address of the next request to issue
  logic [31:0] m_ghost_addr;
  logic [31:0] want_pc;     // PC decode must see next, in program order

  always #5 CLK = ~CLK;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iren(iren), .iaddr(iaddr), .ihready(ihready), .irdata(irdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .f2d_en(f2d_en), .f2d_flush(f2d_flush), .f2d_pc(f2d_pc),
    .f2d_inst(f2d_inst), .f2d_pred(f2d_pred), .f2d_target(f2d_target)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic bit btb_hit(input logic [31:0] a);
    return (dir_on && a == dir_pc) || (btb_on && a[5:2] == 4'hB);
  endfunction

  function automatic logic [31:0] btb_tgt(input logic [31:0] a);
    if (dir_on && a == dir_pc) return dir_tgt;
    return a + 32'h0000_0105;
  endfunction

  // memory and BTB responders
  always_comb begin
    irdata = ihready ? mem_word(iaddr) : junk;
  end

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = 32'h0;
    if (dir_on && iaddr == dir_pc) begin
      pred_taken  = 1'b1;
      pred_target = dir_tgt;
    end else if (btb_on && iaddr[5:2] == 4'hB) begin
      pred_taken  = 1'b1;
      pred_target = iaddr + 32'h0000_0105;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fresh = 1'b1;
    m_held  = 1'b0;
    m_ghost = 1'b0;
    m_pc    = 32'h0;
    want_pc = 32'h0;
  endtask

  // One clock: check outputs mid-cycle, advance the model, return just after the edge
  task automatic cycle();
    logic        e_iren, e_en, e_flush;
    logic [31:0] rmask;
    @(negedge CLK);
    rmask = redirect_pc & ~32'h3;
    if (!nRST || m_fresh) begin
      e_iren = 1'b0; e_en = 1'b0; e_flush = 1'b1;
    end else if (m_ghost) begin
      e_iren = 1'b1; e_en = 1'b0; e_flush = redirect;
    end else if (m_held) begin
      e_iren = 1'b0; e_en = !redirect && !stall; e_flush = redirect;
    end else begin
      e_iren = 1'b1; e_en = ihready && !stall && !redirect; e_flush = redirect;
    end
    chk("iren", {31'b0, iren}, {31'b0, e_iren});
    chk("f2d_en", {31'b0, f2d_en}, {31'b0, e_en});
    chk("f2d_flush", {31'b0, f2d_flush}, {31'b0, e_flush});
    if (e_iren) chk("iaddr", iaddr, m_ghost ? m_ghost_addr : m_pc);
    if (!nRST || m_fresh) chk("reset_inst", f2d_inst, NOP);
    if (e_en) begin
      chk("f2d_pc", f2d_pc, want_pc);
      chk("f2d_inst", f2d_inst, mem_word(want_pc));
      chk("f2d_pred", {31'b0, f2d_pred}, {31'b0, btb_hit(want_pc)});
      if (btb_hit(want_pc)) chk("f2d_target", f2d_target, btb_tgt(want_pc));
      want_pc = btb_hit(want_pc) ? (btb_tgt(want_pc) & ~32'h3) : want_pc + 32'd4;
    end
    // advance the model across the coming edge
    if (!nRST) begin
      model_reset();
    end else if (m_fresh) begin
      m_fresh = 1'b0;
      if (redirect) m_pc = rmask;
    end else if (m_ghost) begin
      if (redirect) m_pc = rmask;
      if (ihready) m_ghost = 1'b0;
    end else if (m_held) begin
      if (redirect) begin
        m_held = 1'b0;
        m_pc   = rmask;
      end else if (!stall) begin
        m_held = 1'b0;
      end
    end else if (redirect) begin
      if (!ihready) begin
        m_ghost      = 1'b1;
        m_ghost_addr = m_pc;
      end
      m_pc = rmask;
    end else if (ihready) begin
      if (stall) m_held = 1'b1;
      m_pc = btb_hit(m_pc) ? (btb_tgt(m_pc) & ~32'h3) : m_pc + 32'd4;
    end
    if (nRST && redirect) want_pc = rmask;
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_inputs();
    ihready     = ($urandom_range(0, 3) != 0);
    stall       = ($urandom_range(0, 3) == 0);
    redirect    = ($urandom_range(0, 15) == 0);
    redirect_pc = $urandom & 32'h0000_0FFF;
    junk        = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; ihready = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; junk = 32'hDEAD_BEEF;
    btb_on = 1'b0; dir_on = 1'b0; dir_pc = 32'h0; dir_tgt = 32'h0;
    model_reset();
    @(posedge CLK); #1;

    // reset held for three cycles, then released
    repeat (3) cycle();
    nRST = 1'b1;
    cycle();
    chk("first_iaddr", iaddr, 32'h0);

    // back-to-back fetches
    ihready = 1'b1;
    repeat (2) cycle();
    chk("seq_iaddr_8", iaddr, 32'h8);

    // memory wait states at 0x8
    ihready = 1'b0;
    repeat (2) cycle();
    chk("wait_iaddr_8", iaddr, 32'h8);
    ihready = 1'b1;
    cycle();
    chk("after_wait_iaddr", iaddr, 32'hC);
    cycle();

    // decode stall as inst@0x10 returns
    stall = 1'b1;
    cycle();
    ihready = 1'b0;
    repeat (2) cycle();
    stall = 1'b0;
    cycle();
    chk("after_hold_iaddr", iaddr, 32'h14);

    // redirect while fetch of 0x14 is outstanding
    cycle();
    redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0;
    chk("drain_iaddr_kept", iaddr, 32'h14);
    cycle();
    ihready = 1'b1;
    cycle();
    chk("redirect_iaddr", iaddr, 32'h100);

    // predicted-taken branch at 0x104 -> 0x40
    dir_on = 1'b1; dir_pc = 32'h104; dir_tgt = 32'h40;
    repeat (2) cycle();
    chk("pred_iaddr", iaddr, 32'h40);
    dir_on = 1'b0;

    // redirect and stall in the same cycle
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    cycle();
    stall = 1'b0; redirect = 1'b0;
    chk("redir_stall_iaddr", iaddr, 32'h200);

    // redirect while holding
    stall = 1'b1;
    cycle();
    redirect = 1'b1; redirect_pc = 32'h300;
    cycle();
    redirect = 1'b0; stall = 1'b0;
    chk("hold_redir_iaddr", iaddr, 32'h300);
    cycle();

    // repeated redirects during a drain
    ihready = 1'b0; redirect = 1'b1; redirect_pc = 32'h400;
    cycle();
    redirect_pc = 32'h500;
    cycle();
    redirect_pc = 32'h603; ihready = 1'b1;
    cycle();
    redirect = 1'b0;
    chk("drain_redir_iaddr", iaddr, 32'h600);

    // PC wraparound
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF6;
    cycle();
    redirect = 1'b0;
    repeat (3) cycle();
    chk("wrap_iaddr", iaddr, 32'h0);

    // randomized traffic
    btb_on = 1'b1;
    for (int i = 0; i < 800; i++) begin
      rand_inputs();
      cycle();
    end

    // asynchronous reset mid-transaction
    ihready = 1'b0; stall = 1'b0; redirect = 1'b0;
    cycle();
    nRST = 1'b0;
    #1;
    chk("async_rst_iren", {31'b0, iren}, 32'h0);
    chk("async_rst_flush", {31'b0, f2d_flush}, 32'h1);
    chk("async_rst_inst", f2d_inst, NOP);
    repeat (2) cycle();
    nRST = 1'b1;
    cycle();
    chk("rst2_iaddr", iaddr, 32'h0);
    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
